exe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32I core (IF, ID, EX, MEM, WB). It tracks the destination registers of the instructions in EX, MEM and WB and drives the EX-stage operand forwarding selects. It inserts a one-cycle bubble on a load-use dependency, flushes the wrong-path instructions on a taken branch, and freezes the whole pipeline while data memory is busy. Free-running counters record stall and flush cycles for performance debug.

---
 rtl/exe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_exe_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_hazard_ctrl.sv
// EX hazard controller: shadow EX/MEM/WB slots, operand forwarding,
// load-use bubble, branch flush, memory freeze, stall/flush counters.
module exe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             freeze,
  output logic             pc_sel_branch,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } slot_t;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    FLUSH,
    FREEZE
  } state_t;

  slot_t  ex_q, mem_q, wb_q, id_s;
  state_t state_q, state_d;

  logic lu, act_frz, act_br, act_lu;

  function automatic logic wmatch(
    input slot_t      s,
    input logic [4:0] r
  );
    return s.v & s.wr & (s.rd != 5'd0) & (s.rd == r);
  endfunction

  assign id_s = '{
    v:   id_valid,
    rd:  id_rd,
    wr:  id_reg_write,
    ld:  id_is_load,
    rs1: id_rs1,
    rs2: id_rs2,
    u1:  id_use_rs1,
    u2:  id_use_rs2
  };

  always_comb begin
    fwd_a = 2'b00;
    if (ex_q.u1 && wmatch(mem_q, ex_q.rs1))
      fwd_a = 2'b01;
    else if (ex_q.u1 && wmatch(wb_q, ex_q.rs1))
      fwd_a = 2'b10;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (ex_q.u2 && wmatch(mem_q, ex_q.rs2))
      fwd_b = 2'b01;
    else if (ex_q.u2 && wmatch(wb_q, ex_q.rs2))
      fwd_b = 2'b10;
  end

  assign lu = id_valid & ex_q.v & ex_q.ld & ex_q.wr
            & (ex_q.rd != 5'd0)
            & ((id_use_rs1 & (id_rs1 == ex_q.rd))
             | (id_use_rs2 & (id_rs2 == ex_q.rd)));

  assign act_frz = mem_busy;
  assign act_br  = ~mem_busy & ex_branch_taken & ex_q.v;
  assign act_lu  = ~mem_busy & ~act_br & lu;

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    freeze        = 1'b0;
    pc_sel_branch = 1'b0;
    state_d       = RUN;
    unique case (1'b1)
      act_frz: begin
        freeze  = 1'b1;
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        state_d = FREEZE;
      end
      act_br: begin
        pc_sel_branch = 1'b1;
        flush_ifid    = 1'b1;
        flush_idex    = 1'b1;
        state_d       = FLUSH;
      end
      act_lu: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        flush_idex = 1'b1;
        state_d    = LU_STALL;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= flush_idex ? '0 : id_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state_q == LU_STALL || state_q == FREEZE)
          && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (state_q == FLUSH && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Source fields of MEM/WB slots ride along for debug only.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{mem_q.ld, mem_q.rs1, mem_q.rs2,
                              mem_q.u1, mem_q.u2,
                              wb_q.ld, wb_q.rs1, wb_q.rs2,
                              wb_q.u1, wb_q.u2};

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed self-checking bench for exe_hazard_ctrl.
// Second instance (CNT_W=4) runs under permanent mem_busy.
module tb_exe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst2_n = 1'b0;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       id_reg_write, id_is_load;
  logic       ex_branch_taken, mem_busy;

  logic        pc_en, ifid_en, flush_ifid, flush_idex;
  logic        freeze, pc_sel_branch;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic       pc_en2, ifid_en2, flush_ifid2, flush_idex2;
  logic       freeze2, pc_sel_branch2;
  logic [1:0] fwd_a2, fwd_b2;
  logic [3:0] stall_cnt2, flush_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .freeze(freeze), .pc_sel_branch(pc_sel_branch),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  exe_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst2_n),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy(1'b1),
    .pc_en(pc_en2), .ifid_en(ifid_en2),
    .flush_ifid(flush_ifid2), .flush_idex(flush_idex2),
    .freeze(freeze2), .pc_sel_branch(pc_sel_branch2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid        = 1'b0;
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    id_use_rs1      = 1'b0;
    id_use_rs2      = 1'b0;
    id_rd           = 5'd0;
    id_reg_write    = 1'b0;
    id_is_load      = 1'b0;
    ex_branch_taken = 1'b0;
    mem_busy        = 1'b0;
  endtask

  task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2,
                     input logic [4:0] rd, input logic ld);
    id_valid     = 1'b1;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_use_rs1   = u1;
    id_use_rs2   = u2;
    id_rd        = rd;
    id_reg_write = 1'b1;
    id_is_load   = ld;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    mem_busy = 1'b1;
    #1;
    chk("rst_freeze_busy", {31'd0, freeze}, 32'd1);
    chk("rst_pc_en_busy", {31'd0, pc_en}, 32'd0);
    do_reset();
    rst2_n = 1'b1;
    #1;
    chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
    chk("rst_ifid_en", {31'd0, ifid_en}, 32'd1);
    chk("rst_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);

    // ADD x5,x1,x2 ; SUB x6,x5,x3 -> MEM forward
    ins(5'd1, 5'd2, 1, 1, 5'd5, 0);
    cyc();
    ins(5'd5, 5'd3, 1, 1, 5'd6, 0);
    #1;
    chk("mem_fwd_nostall", {31'd0, pc_en}, 32'd1);
    cyc();
    idle();
    #1;
    chk("mem_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("mem_fwd_b", {30'd0, fwd_b}, 32'd0);

    // one independent instruction between -> WB forward
    do_reset();
    ins(5'd1, 5'd2, 1, 1, 5'd5, 0);
    cyc();
    ins(5'd1, 5'd2, 1, 1, 5'd9, 0);
    cyc();
    ins(5'd5, 5'd3, 1, 1, 5'd6, 0);
    cyc();
    idle();
    #1;
    chk("wb_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("wb_fwd_b", {30'd0, fwd_b}, 32'd0);

    // x5 written twice: MEM wins over WB on both operands
    do_reset();
    ins(5'd1, 5'd2, 1, 1, 5'd5, 0);
    cyc();
    ins(5'd3, 5'd4, 1, 1, 5'd5, 0);
    cyc();
    ins(5'd5, 5'd5, 1, 1, 5'd6, 0);
    cyc();
    idle();
    #1;
    chk("prio_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("prio_fwd_b", {30'd0, fwd_b}, 32'd1);

    // LW x7 ; ADD x8,x7,x7 -> one bubble then WB forward
    do_reset();
    ins(5'd1, 5'd0, 1, 0, 5'd7, 1);
    cyc();
    ins(5'd7, 5'd7, 1, 1, 5'd8, 0);
    #1;
    chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
    chk("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
    chk("lu_flush_idex", {31'd0, flush_idex}, 32'd1);
    cyc();
    #1;
    chk("lu_once_pc_en", {31'd0, pc_en}, 32'd1);
    chk("lu_once_flush", {31'd0, flush_idex}, 32'd0);
    cyc();
    idle();
    #1;
    chk("lu_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("lu_fwd_b", {30'd0, fwd_b}, 32'd2);
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // LW x0 ; ADD x1,x0,x0 -> nothing
    do_reset();
    ins(5'd1, 5'd0, 1, 0, 5'd0, 1);
    cyc();
    ins(5'd0, 5'd0, 1, 1, 5'd1, 0);
    #1;
    chk("x0_pc_en", {31'd0, pc_en}, 32'd1);
    chk("x0_flush_idex", {31'd0, flush_idex}, 32'd0);
    cyc();
    idle();
    #1;
    chk("x0_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);

    // taken branch; ignored while ex_q is a bubble
    do_reset();
    ins(5'd1, 5'd2, 1, 1, 5'd3, 0);
    ex_branch_taken = 1'b1;
    #1;
    chk("br_bubble_sel", {31'd0, pc_sel_branch}, 32'd0);
    cyc();
    ins(5'd4, 5'd5, 1, 1, 5'd6, 0);
    #1;
    chk("br_sel", {31'd0, pc_sel_branch}, 32'd1);
    chk("br_flush", {30'd0, flush_ifid, flush_idex}, 32'd3);
    chk("br_pc_en", {31'd0, pc_en}, 32'd1);
    cyc();
    idle();
    #1;
    chk("br_once_sel", {31'd0, pc_sel_branch}, 32'd0);
    chk("br_once_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
    cyc();
    chk("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    chk("br_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // branch and load-use together: branch wins
    do_reset();
    ins(5'd1, 5'd0, 1, 0, 5'd7, 1);
    cyc();
    ins(5'd7, 5'd7, 1, 1, 5'd8, 0);
    ex_branch_taken = 1'b1;
    #1;
    chk("brlu_pc_en", {31'd0, pc_en}, 32'd1);
    chk("brlu_sel", {31'd0, pc_sel_branch}, 32'd1);
    chk("brlu_flush_idex", {31'd0, flush_idex}, 32'd1);
    cyc();
    idle();
    #1;
    chk("brlu_after_pc_en", {31'd0, pc_en}, 32'd1);

    // freeze 3 cycles over a load-use pair
    do_reset();
    ins(5'd1, 5'd0, 1, 0, 5'd7, 1);
    cyc();
    ins(5'd7, 5'd7, 1, 1, 5'd8, 0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_freeze", {31'd0, freeze}, 32'd1);
      chk("frz_pc_en", {31'd0, pc_en}, 32'd0);
      chk("frz_flush_idex", {31'd0, flush_idex}, 32'd0);
      cyc();
    end
    mem_busy = 1'b0;
    #1;
    chk("frz_rel_freeze", {31'd0, freeze}, 32'd0);
    chk("frz_rel_lu", {31'd0, flush_idex}, 32'd1);
    chk("frz_rel_pc_en", {31'd0, pc_en}, 32'd0);
    cyc();
    #1;
    chk("frz_run_pc_en", {31'd0, pc_en}, 32'd1);
    cyc();
    idle();
    #1;
    chk("frz_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("frz_stall_cnt", {16'd0, stall_cnt}, 32'd4);

    // async reset in the middle of a load-use stall
    do_reset();
    ins(5'd1, 5'd0, 1, 0, 5'd7, 1);
    cyc();
    ins(5'd7, 5'd7, 1, 1, 5'd8, 0);
    #1;
    chk("rstlu_pre_pc_en", {31'd0, pc_en}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstlu_pc_en", {31'd0, pc_en}, 32'd1);
    chk("rstlu_ifid_en", {31'd0, ifid_en}, 32'd1);
    chk("rstlu_flush_idex", {31'd0, flush_idex}, 32'd0);
    do_reset();

    // saturation of the CNT_W=4 instance
    chk("sat_stall", {28'd0, stall_cnt2}, 32'd15);
    repeat (3) cyc();
    chk("sat_hold", {28'd0, stall_cnt2}, 32'd15);
    chk("sat_flush", {28'd0, flush_cnt2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
